dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH_LOG2, default 5, gives the log2 of the number of words in the shared data memory.
REQ-002 Clk  input  1  clock; all state changes on the posedge.
REQ-003 Clrn  input  1  reset; asynchronous, active-low.
REQ-004 reqN (N=0,1)  input  1  access request from requester N.
REQ-005 weN  input  1  requester N write enable: 1 = write, 0 = read.
REQ-006 addrN  input  32  requester N byte address.
REQ-007 wdataN  input  32  requester N write data.
REQ-008 ackN  output  1  one-cycle access-complete pulse to requester N.
REQ-009 errN  output  1  error flag, valid only while ackN=1.
REQ-010 rdataN  output  32  read data to requester N, valid while ackN=1.
REQ-011 MAddr  output  32  memory address.
REQ-012 MDin  output  32  memory write data.
REQ-013 MWe  output  1  memory write enable; the memory writes on the posedge when MWe=1.
REQ-014 MDout  input  32  combinational memory read data, indexed by MAddr[DEPTH_LOG2+1:2].
REQ-015 busy  output  1  set when the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-017 IDLE: if any reqN=1, the block SHALL go to ACC on the edge, capturing the winner's addr, wdata and we into MAddr, MDin and an internal we latch; otherwise it stays in IDLE.
REQ-018 Arbitration SHALL be round-robin using a last-served pointer: if one port requests, that port wins; if both request, the port that is not last-served wins.
REQ-019 The pointer SHALL update to the winner on the IDLE->ACC edge.
REQ-020 ACC SHALL last exactly one cycle and then go to DONE.
REQ-021 In ACC, MWe SHALL equal the latched we AND NOT err; it SHALL be 0 in all other states.
REQ-022 err SHALL be 1 when addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0; err is computed at capture.
REQ-023 On the ACC->DONE edge, rdataN SHALL register MDout for a read without error, and 0 for a write or an error.
REQ-024 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-025 In DONE, ackN SHALL be 1 for the served port only, with errN valid.
REQ-026 In DONE, ack and err for the other port SHALL be 0.
REQ-027 Requester rule: hold req, we, addr and wdata stable from req assertion until ack.
REQ-028 Requester rule: in the cycle after ack, either deassert req or present a new access; a req seen in IDLE is always a new access.
REQ-029 Request-to-ack latency SHALL be 2 cycles when uncontended (req sampled at edge k, ack high during cycle k+2).
REQ-030 The write SHALL commit at the ACC->DONE edge.
REQ-031 Throughput SHALL be 1 access per 3 cycles.
REQ-032 A requester losing arbitration SHALL be served in the next arbitration if it keeps req high, giving a worst-case wait of 3 cycles.
REQ-033 reqN changes during ACC or DONE SHALL be ignored.
REQ-034 rdataN SHALL hold its last value outside DONE.
REQ-035 busy SHALL be registered, equal to (state!=IDLE).

Reset
REQ-036 While Clrn=0: state=IDLE, pointer=1 (port 0 wins the first tie), MWe=0, MAddr=0, MDin=0, ack0/1=0, err0/1=0, rdata0/1=0, busy=0.
REQ-037 Reset asserted during ACC SHALL force MWe=0 immediately, so no write occurs and no ack is issued.
REQ-038 Operation SHALL resume on the first edge after Clrn rises.

Verification
REQ-039 Uncontended write then read: port 0 writes 0xDEADBEEF to 0x0C, then reads 0x0C -> ack0 arrives 2 cycles after each req, rdata0=0xDEADBEEF, and MWe is high for exactly 1 cycle.
REQ-040 Tie after reset: req0 and req1 are asserted on the same edge -> port 0 is served first and port 1 gets ack1 3 cycles after ack0.
REQ-041 Fairness: both ports hold req continuously for 6 accesses -> acks strictly alternate 0,1,0,1,0,1.
REQ-042 Errors: port 1 writes to 0x80, then to 0x06 (DEPTH_LOG2=5) -> ack1 and err1 both 1, MWe stays 0, and a read of word 0 is unchanged.
REQ-043 Reset mid-access: Clrn pulses low during ACC of a write of 0x12345678 to 0x10 -> no write (0x10 reads back its old value), no ack, and all outputs return to their reset values.
REQ-044 Address wrap: a write to 0x7C, the last word, followed by a read -> data is returned correctly and err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving two requesters access to one single-ported data memory.
// Every access walks IDLE -> ACC (memory driven) -> DONE (ack pulse), three cycles each.
module dmem_arbiter #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic [31:0] MAddr,
    output logic [31:0] MDin,
    output logic        MWe,
    input  logic [31:0] MDout,
    output logic        busy,
    output logic [1:0]  state_dbg
);
    // Handshake: a requester raises reqN with we/addr/wdata and holds all of them until the
    // single-cycle ackN; a req seen while IDLE is always taken as a new access.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        ptr;
    logic        sel;
    logic        we_l;
    logic        err_l;
    logic        any_req;
    logic        win;
    logic        win_we;
    logic        win_err;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;

    assign any_req = req0 | req1;
    // Port 1 wins when it requests alone, or on a tie when port 0 was served last.
    assign win       = req1 & (~req0 | ~ptr);
    assign win_we    = win ? we1 : we0;
    assign win_addr  = win ? addr1 : addr0;
    assign win_wdata = win ? wdata1 : wdata0;
    assign win_err   = (win_addr[1:0] != 2'b00) || (win_addr[31:DEPTH_LOG2+2] != '0);

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ACC;
            ACC:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            ptr    <= 1'b1;
            sel    <= 1'b0;
            we_l   <= 1'b0;
            err_l  <= 1'b0;
            MAddr  <= '0;
            MDin   <= '0;
            rdata0 <= '0;
            rdata1 <= '0;
            busy   <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (state == IDLE && any_req) begin
                ptr   <= win;
                sel   <= win;
                we_l  <= win_we;
                err_l <= win_err;
                MAddr <= win_addr;
                MDin  <= win_wdata;
            end
            // Writes and faulted accesses return zero so stale memory data never leaks out.
            if (state == ACC) begin
                if (sel) rdata1 <= (we_l || err_l) ? '0 : MDout;
                else     rdata0 <= (we_l || err_l) ? '0 : MDout;
            end
        end
    end

    always_comb begin
        MWe       = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        state_dbg = state;
        if (state == ACC) MWe = we_l & ~err_l;
        if (state == DONE) begin
            ack0 = ~sel;
            ack1 = sel;
            err0 = ~sel & err_l;
            err1 = sel & err_l;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter, checked every cycle against a
// transaction-level model of arbitration order, access timing and memory contents.
module tb_dmem_arbiter;
    localparam int DL    = 5;
    localparam int WORDS = 1 << DL;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        Clk;
    logic        Clrn;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, err0, ack1, err1, MWe, busy;
    logic [31:0] rdata0, rdata1, MAddr, MDin, MDout;
    logic [1:0]  state_dbg;

    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];

    int n_checks;
    int n_fail;
    int cyc;

    // reference model
    int          next_arb;
    int          last_srv;
    bit          pend;
    int          pend_edge;
    int          pend_port;
    txn_t        pend_t;
    bit          pend_err;
    logic [31:0] rd_exp0, rd_exp1;
    logic [33:0] exp_q[$];

    // requester drivers
    txn_t tq0[$];
    txn_t tq1[$];
    bit   act0, act1;
    int   start0, start1;
    int   lat0, lat1;
    bit   last_err0, last_err1;
    bit   rand_mode;
    int   mwe_cnt;
    int   ack_edges[$];
    int   ack_ports[$];

    dmem_arbiter #(.DEPTH_LOG2(DL)) dut (
        .Clk(Clk), .Clrn(Clrn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .MAddr(MAddr), .MDin(MDin), .MWe(MWe), .MDout(MDout),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset block
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // memory: combinational read, write on the edge while MWe is high
    assign MDout = mem[MAddr[DL+1:2]];
    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        forever begin
            @(posedge Clk);
            if (MWe) mem[MAddr[DL+1:2]] <= MDin;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(WORDS * 4));
    endfunction

    function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   k;
        k       = $urandom_range(0, 9);
        t.we    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        t.addr  = 32'($urandom_range(0, WORDS - 1)) << 2;
        if (k == 0)      t.addr = t.addr | 32'($urandom_range(1, 3));
        else if (k == 1) t.addr = t.addr + (32'($urandom_range(1, 255)) << (DL + 2));
        return t;
    endfunction

    task automatic model_reset();
        pend     = 0;
        next_arb = 0;
        last_srv = 1;
        rd_exp0  = '0;
        rd_exp1  = '0;
        exp_q.delete();
    endtask

    // One arbitration every three edges at most; the served access completes one edge later.
    task automatic model_edge(input int e);
        logic [31:0] d;
        int          w;
        if (pend && e == pend_edge + 1) begin
            d = '0;
            if (!pend_err) begin
                if (pend_t.we) ref_mem[pend_t.addr[DL+1:2]] = pend_t.wdata;
                else           d = ref_mem[pend_t.addr[DL+1:2]];
            end
            if (pend_port == 0) rd_exp0 = d;
            else                rd_exp1 = d;
            exp_q.push_back({pend_port[0], pend_err, d});
        end
        if (pend && e >= pend_edge + 2) pend = 0;
        if (!pend && e >= next_arb && (req0 || req1)) begin
            if (req0 && req1) w = 1 - last_srv;
            else              w = req1 ? 1 : 0;
            last_srv  = w;
            pend      = 1;
            pend_edge = e;
            pend_port = w;
            next_arb  = e + 3;
            pend_t    = (w == 1) ? mk(we1, addr1, wdata1) : mk(we0, addr0, wdata0);
            pend_err  = addr_err(pend_t.addr);
        end
    endtask

    task automatic check_outputs(input int e);
        bit          in_acc, in_done, a0, a1;
        logic [33:0] x;
        in_acc  = pend && e == pend_edge;
        in_done = pend && e == pend_edge + 1;
        a0      = in_done && pend_port == 0;
        a1      = in_done && pend_port == 1;
        check("busy", 32'(busy), 32'(in_acc || in_done));
        check("state_idle", 32'(state_dbg == 2'd0), 32'(!(in_acc || in_done)));
        check("mwe", 32'(MWe), 32'(in_acc && pend_t.we && !pend_err));
        if (in_acc) begin
            check("maddr", MAddr, pend_t.addr);
            check("mdin", MDin, pend_t.wdata);
        end
        check("ack0", 32'(ack0), 32'(a0));
        check("ack1", 32'(ack1), 32'(a1));
        if (in_done) begin
            check("err0", 32'(err0), 32'(a0 && pend_err));
            check("err1", 32'(err1), 32'(a1 && pend_err));
        end
        check("rdata0", rdata0, rd_exp0);
        check("rdata1", rdata1, rd_exp1);
        if (ack0 || ack1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ack", 32'(1), 32'(0));
            end else begin
                x = exp_q.pop_front();
                check("sb_port", 32'(ack1), 32'(x[33]));
                check("sb_err", 32'(ack1 ? err1 : err0), 32'(x[32]));
                check("sb_data", ack1 ? rdata1 : rdata0, x[31:0]);
            end
        end
    endtask

    // driver tasks
    task automatic drive_ports(input int e);
        txn_t t;
        if (act0 && ack0) begin
            act0 = 0; lat0 = e + 1 - start0; last_err0 = err0;
            ack_edges.push_back(e); ack_ports.push_back(0);
            req0 = 0; we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
        end
        if (act1 && ack1) begin
            act1 = 0; lat1 = e + 1 - start1; last_err1 = err1;
            ack_edges.push_back(e); ack_ports.push_back(1);
            req1 = 0; we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
        end
        if (!act0 && tq0.size() > 0 && (!rand_mode || $urandom_range(0, 2) == 0)) begin
            t = tq0.pop_front();
            req0 = 1; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata;
            act0 = 1; start0 = e + 1;
        end
        if (!act1 && tq1.size() > 0 && (!rand_mode || $urandom_range(0, 2) == 0)) begin
            t = tq1.pop_front();
            req1 = 1; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata;
            act1 = 1; start1 = e + 1;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        if (Clrn) begin
            model_edge(cyc);
            check_outputs(cyc);
            if (MWe) mwe_cnt++;
            drive_ports(cyc);
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((tq0.size() > 0 || tq1.size() > 0 || act0 || act1 || pend) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(tq0.size() > 0 || tq1.size() > 0 || act0 || act1 || pend), 32'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_mwe"}, 32'(MWe), 32'(0));
        check({tag, "_maddr"}, MAddr, 32'(0));
        check({tag, "_mdin"}, MDin, 32'(0));
        check({tag, "_ack"}, 32'({ack0, ack1}), 32'(0));
        check({tag, "_err"}, 32'({err0, err1}), 32'(0));
        check({tag, "_rdata0"}, rdata0, 32'(0));
        check({tag, "_rdata1"}, rdata1, 32'(0));
    endtask

    task automatic do_reset();
        Clrn = 0;
        req0 = 0; req1 = 0; act0 = 0; act1 = 0;
        tq0.delete(); tq1.delete();
        model_reset();
        tick();
        tick();
        check_reset_values("rst");
        Clrn = 1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; mwe_cnt = 0; rand_mode = 0;
        we0 = 0; addr0 = '0; wdata0 = '0; we1 = 0; addr1 = '0; wdata1 = '0;
        lat0 = 0; lat1 = 0; last_err0 = 0; last_err1 = 0;
        do_reset();

        // tie straight after reset: port 0 first, port 1 three cycles later
        ack_edges.delete(); ack_ports.delete();
        tq0.push_back(mk(1'b0, 32'h04, 32'h0));
        tq1.push_back(mk(1'b0, 32'h08, 32'h0));
        run_until_idle(50);
        check("tie_acks", 32'(ack_ports.size()), 32'(2));
        if (ack_ports.size() >= 2) begin
            check("tie_first", 32'(ack_ports[0]), 32'(0));
            check("tie_gap", 32'(ack_edges[1] - ack_edges[0]), 32'(3));
        end

        // uncontended write then read on port 0
        mwe_cnt = 0;
        tq0.push_back(mk(1'b1, 32'h0C, 32'hDEADBEEF));
        run_until_idle(50);
        check("wr_latency", 32'(lat0), 32'(2));
        tq0.push_back(mk(1'b0, 32'h0C, 32'h0));
        run_until_idle(50);
        check("rd_latency", 32'(lat0), 32'(2));
        check("rd_deadbeef", rdata0, 32'hDEADBEEF);
        check("mwe_once", 32'(mwe_cnt), 32'(1));

        // fairness: both ports keep requesting for six accesses
        do_reset();
        ack_edges.delete(); ack_ports.delete();
        for (int i = 0; i < 3; i++) begin
            tq0.push_back(mk(1'b1, 32'(i * 8), 32'hF0F0_0000 + 32'(i)));
            tq1.push_back(mk(1'b0, 32'(i * 8 + 4), 32'h0));
        end
        run_until_idle(100);
        check("fair_count", 32'(ack_ports.size()), 32'(6));
        for (int i = 0; i < 6 && i < ack_ports.size(); i++) begin
            check("fair_order", 32'(ack_ports[i]), 32'(i % 2));
            if (i > 0) check("fair_gap", 32'(ack_edges[i] - ack_edges[i-1]), 32'(3));
        end

        // faulted writes must not touch memory
        tq1.push_back(mk(1'b1, 32'h00, 32'hA5A5_0001));
        run_until_idle(50);
        mwe_cnt = 0;
        tq1.push_back(mk(1'b1, 32'h80, 32'h1111_1111));
        run_until_idle(50);
        check("err_0x80", 32'(last_err1), 32'(1));
        tq1.push_back(mk(1'b1, 32'h06, 32'h2222_2222));
        run_until_idle(50);
        check("err_0x06", 32'(last_err1), 32'(1));
        check("err_no_mwe", 32'(mwe_cnt), 32'(0));
        tq1.push_back(mk(1'b0, 32'h00, 32'h0));
        run_until_idle(50);
        check("err_word0", rdata1, 32'hA5A5_0001);
        check("err_rd_ok", 32'(last_err1), 32'(0));

        // last word of the memory
        tq0.push_back(mk(1'b1, 32'h7C, 32'hCAFE_F00D));
        tq0.push_back(mk(1'b0, 32'h7C, 32'h0));
        run_until_idle(50);
        check("wrap_data", rdata0, 32'hCAFE_F00D);
        check("wrap_err", 32'(last_err0), 32'(0));

        // reset pulse during ACC of a write
        tq0.push_back(mk(1'b1, 32'h10, 32'h0BAD_F00D));
        run_until_idle(50);
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'h1234_5678;
        act0 = 1; start0 = cyc + 1;
        tick();
        check("mid_in_acc", 32'(MWe), 32'(1));
        Clrn = 0;
        #1;
        check_reset_values("rst_mid");
        req0 = 0; act0 = 0;
        model_reset();
        #1;
        Clrn = 1;
        for (int i = 0; i < 3; i++) tick();
        tq0.push_back(mk(1'b0, 32'h10, 32'h0));
        run_until_idle(50);
        check("mid_old_value", rdata0, 32'h0BAD_F00D);

        // randomized traffic from both ports
        rand_mode = 1;
        for (int i = 0; i < 80; i++) begin
            tq0.push_back(rand_txn());
            tq1.push_back(rand_txn());
        end
        run_until_idle(4000);
        for (int i = 0; i < 4; i++) tick();
        check("sb_leftover", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
